fcmp_arb: RTL and testbench

FCMP_ARB -- requirements
Module: fcmp_arb

---
 rtl/fcmp_pkg.sv | 21 ++
 rtl/fcmp.sv | 42 ++++
 rtl/fcmp_arb.sv | 166 ++++++++++++++++
 tb/tb_fcmp_arb.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fcmp_pkg.sv
// rtl/fcmp_pkg.sv - shared flag struct, FSM state enum and defaults for the fcmp arbiter
package fcmp_pkg;

  localparam int FCMP_NREQ_DEFAULT = 4;

  typedef struct packed {
    logic unordered;
    logic altb;
    logic blta;
    logic aeqb;
    logic inf;
    logic zero;
  } fcmp_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/fcmp.sv
// rtl/fcmp.sv - single-precision IEEE-754 compare unit producing six relation/class flags
module fcmp
  import fcmp_pkg::*;
(
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  output fcmp_flags_t flags_o
);

  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        unord;
  logic [31:0] key_a, key_b;

  assign a_nan  = (&opa_i[30:23]) & (|opa_i[22:0]);
  assign b_nan  = (&opb_i[30:23]) & (|opb_i[22:0]);
  assign a_inf  = (&opa_i[30:23]) & ~(|opa_i[22:0]);
  assign b_inf  = (&opb_i[30:23]) & ~(|opb_i[22:0]);
  assign a_zero = ~(|opa_i[30:0]);
  assign b_zero = ~(|opb_i[30:0]);
  assign unord  = a_nan | b_nan;

  // Sign-magnitude to unsigned order: negatives bit-inverted, positives lifted above them.
  assign key_a = opa_i[31] ? ~opa_i : {1'b1, opa_i[30:0]};
  assign key_b = opb_i[31] ? ~opb_i : {1'b1, opb_i[30:0]};

  always_comb begin
    flags_o           = '0;
    flags_o.unordered = unord;
    flags_o.inf       = a_inf | b_inf;
    flags_o.zero      = a_zero | b_zero;
    if (!unord) begin
      if (a_zero && b_zero) begin
        flags_o.aeqb = 1'b1;
      end else begin
        flags_o.aeqb = (key_a == key_b);
        flags_o.altb = (key_a < key_b);
        flags_o.blta = (key_a > key_b);
      end
    end
  end

endmodule

// File: rtl/fcmp_arb.sv
// rtl/fcmp_arb.sv - round-robin arbiter sharing one fcmp across NREQ requesters
// Optional sticky per-requester unordered-result flags under macro FCMP_ARB_UNORD_ERR_EN.
module fcmp_arb
  import fcmp_pkg::*;
#(
  parameter int NREQ = FCMP_NREQ_DEFAULT,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_opa,
  input  logic [NREQ*32-1:0] req_opb,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [5:0]         rsp_flags,
  output logic               busy
`ifdef FCMP_ARB_UNORD_ERR_EN
  ,
  output logic [NREQ-1:0]    unord_err
`endif
);

  arb_state_t  state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [31:0] opa_q, opa_d, opb_q, opb_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  fcmp_flags_t rsp_flags_q, rsp_flags_d;
  fcmp_flags_t eval_flags;

  logic           found;
  logic [IDW-1:0] winner, winner_next;
  logic [31:0]    sel_opa, sel_opb;

  // Two descending passes: the lowest index at/above ptr wins, else the lowest below ptr.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req_valid[j] && (j < int'(ptr_q))) begin
        found  = 1'b1;
        winner = IDW'(j);
      end
    end
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req_valid[j] && (j >= int'(ptr_q))) begin
        found  = 1'b1;
        winner = IDW'(j);
      end
    end
  end

  always_comb begin
    sel_opa = '0;
    sel_opb = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (winner == IDW'(j)) begin
        sel_opa = req_opa[32*j +: 32];
        sel_opb = req_opb[32*j +: 32];
      end
    end
  end

  assign winner_next = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;

  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && found) begin
      req_ready[winner] = 1'b1;
    end
  end

  fcmp u_fcmp (
    .opa_i   (opa_q),
    .opb_i   (opb_q),
    .flags_o (eval_flags)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_flags_d = rsp_flags_q;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          opa_d   = sel_opa;
          opb_d   = sel_opb;
          id_d    = winner;
          ptr_d   = winner_next;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        rsp_flags_d = eval_flags;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_flags = rsp_flags_q;
  assign busy      = (state_q != ST_IDLE);

`ifdef FCMP_ARB_UNORD_ERR_EN
  logic [NREQ-1:0] unord_err_q, unord_err_d;

  always_comb begin
    unord_err_d = unord_err_q;
    if (state_q == ST_RESP && rsp_ready && rsp_flags_q.unordered) begin
      unord_err_d[rsp_id_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unord_err_q <= '0;
    end else begin
      unord_err_q <= unord_err_d;
    end
  end

  assign unord_err = unord_err_q;
`endif

endmodule

// File: tb/tb_fcmp_arb.sv
// tb/tb_fcmp_arb.sv - scoreboard bench for fcmp_arb with a real-number compare reference model
module tb_fcmp_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_opa;
  logic [NREQ*32-1:0] req_opb;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [5:0]         rsp_flags;
  logic               busy;
`ifdef FCMP_ARB_UNORD_ERR_EN
  logic [NREQ-1:0]    unord_err;
`endif

  fcmp_arb #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_opa   (req_opa),
    .req_opb   (req_opb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_flags (rsp_flags),
    .busy      (busy)
`ifdef FCMP_ARB_UNORD_ERR_EN
    ,
    .unord_err (unord_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [5:0] flags;
    int         acc_cyc;
  } exp_t;

  exp_t            sb[$];
  int              grants[$];
  int              errors = 0;
  int              checks = 0;
  int              cyc = 0;
  int              model_ptr = 0;
  int              resp_count = 0;
  logic [NREQ-1:0] model_unord = '0;
  logic [NREQ-1:0] acc_mask = '0;
  logic [NREQ-1:0] vld = '0;
  logic [31:0]     a_arr[NREQ];
  logic [31:0]     b_arr[NREQ];
  logic            prev_valid = 1'b0;
  logic            prev_hold = 1'b0;
  logic [IDW-1:0]  hold_id;
  logic [5:0]      hold_flags;
  logic [IDW-1:0]  last_id;
  logic [5:0]      last_flags;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic real f2r(input logic [31:0] b);
    int  e;
    real m, v;
    e = int'(b[30:23]);
    m = real'(b[22:0]);
    if (e == 255)    v = 1.0e300;
    else if (e == 0) v = m * (2.0 ** (-149));
    else             v = (1.0 + m / 8388608.0) * (2.0 ** (e - 127));
    return b[31] ? -v : v;
  endfunction

  // Flag order {unordered, altb, blta, aeqb, inf, zero}; inf/zero flag either operand.
  function automatic logic [5:0] ref_flags(input logic [31:0] a, input logic [31:0] b);
    logic [5:0] f;
    logic       an, bn;
    real        ra, rb;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ra = f2r(a);
    rb = f2r(b);
    f = '0;
    f[5] = an | bn;
    if (!f[5]) begin
      f[4] = (ra < rb);
      f[3] = (ra > rb);
      f[2] = (ra == rb);
    end
    f[1] = ((a[30:23] == 8'hFF) && (a[22:0] == 0)) || ((b[30:23] == 8'hFF) && (b[22:0] == 0));
    f[0] = (a[30:0] == 0) || (b[30:0] == 0);
    return f;
  endfunction

  // Monitor: arbitration model, scoreboard pop/compare, hold stability and latency.
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_ready;
    logic            model_busy;
    int              w;
    cyc++;
    if (rst) begin
      model_ptr   = 0;
      sb.delete();
      prev_hold   = 1'b0;
      prev_valid  = 1'b0;
      acc_mask    = '0;
      model_unord = '0;
    end else begin
      model_busy = (sb.size() != 0);
      check("busy", busy, model_busy);
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("spurious_rsp_valid", rsp_valid, 0);
        end else begin
          if (!prev_valid) check("latency", cyc - sb[0].acc_cyc, 2);
          if (prev_hold) begin
            check("hold_id", rsp_id, hold_id);
            check("hold_flags", rsp_flags, hold_flags);
          end
          if (rsp_ready) begin
            check("rsp_id", rsp_id, sb[0].id);
            check("rsp_flags", rsp_flags, sb[0].flags);
            if (sb[0].flags[5]) model_unord[sb[0].id] = 1'b1;
            last_id    = rsp_id;
            last_flags = rsp_flags;
            void'(sb.pop_front());
            resp_count++;
            prev_hold = 1'b0;
          end else begin
            prev_hold  = 1'b1;
            hold_id    = rsp_id;
            hold_flags = rsp_flags;
          end
        end
      end else begin
        if (prev_hold) check("hold_valid", rsp_valid, 1);
        prev_hold = 1'b0;
        if (sb.size() != 0 && (cyc - sb[0].acc_cyc) >= 2) check("rsp_valid_late", rsp_valid, 1);
      end
      prev_valid = rsp_valid;

      exp_ready = '0;
      w = -1;
      if (!model_busy) begin
        for (int k = 0; k < NREQ; k++) begin
          if (w < 0 && req_valid[(model_ptr + k) % NREQ]) w = (model_ptr + k) % NREQ;
        end
      end
      if (w >= 0) exp_ready[w] = 1'b1;
      check("req_ready", req_ready, exp_ready);
      acc_mask = exp_ready;
      if (w >= 0) begin
        sb.push_back('{id: w, flags: ref_flags(a_arr[w], b_arr[w]), acc_cyc: cyc});
        grants.push_back(w);
        model_ptr = (w + 1) % NREQ;
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = vld[i];
      req_opa[32*i +: 32]   = a_arr[i];
      req_opb[32*i +: 32]   = b_arr[i];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    vld = vld & ~acc_mask;
    drive();
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    vld[i]   = 1'b1;
    a_arr[i] = a;
    b_arr[i] = b;
    drive();
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((vld != 0 || sb.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (vld != 0 || sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending=%0d valid=%b", sb.size(), vld);
    end
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] sp[12];
    sp = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000, 32'h40000000, 32'h7F800000,
           32'hFF800000, 32'h7FC00000, 32'h00000001, 32'h807FFFFF, 32'h7F7FFFFF, 32'hFFC00001};
    if ($urandom_range(0, 1) == 1) return sp[$urandom_range(0, 11)];
    return $urandom;
  endfunction

  initial begin
    int n;
    int rc;
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    rsp_ready = 1'b1;
    drive();
    repeat (3) @(posedge clk);
    #2;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_rsp_flags", rsp_flags, 0);
    check("reset_busy", busy, 0);
    check("reset_req_ready", req_ready, 0);
    rst = 1'b0;
    step();

    // All four requesters valid from reset: grants 0,1,2,3,0.
    grants.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h3F800000, 32'h3F800000 + i);
    n = 0;
    while (grants.size() < 5 && n < 100) begin
      step();
      for (int i = 0; i < NREQ; i++) vld[i] = 1'b1;
      drive();
      n++;
    end
    vld = '0;
    drive();
    wait_drain(40);
    if (grants.size() < 5) begin
      checks++;
      errors++;
      $display("FAIL grant_count: got %0d expected 5", grants.size());
    end else begin
      check("grant0", grants[0], 0);
      check("grant1", grants[1], 1);
      check("grant2", grants[2], 2);
      check("grant3", grants[3], 3);
      check("grant4", grants[4], 0);
    end

    // 1.0 vs 2.0 from requester 2.
    set_req(2, 32'h3F800000, 32'h40000000);
    wait_drain(20);
    check("req031_id", last_id, 2);
    check("req031_flags", last_flags, 6'b010000);

    // NaN from requester 1.
    set_req(1, 32'h7FC00000, 32'h3F800000);
    wait_drain(20);
    check("req033_flags", last_flags, 6'b100000);
`ifdef FCMP_ARB_UNORD_ERR_EN
    repeat (3) step();
    check("req033_unord_err", unord_err, 4'b0010);
`endif

    // +0 vs -0 with consumer stalled for 5 cycles.
    rc = resp_count;
    rsp_ready = 1'b0;
    set_req(0, 32'h00000000, 32'h80000000);
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    repeat (5) step();
    check("req034_held_no_rsp", resp_count - rc, 0);
    rsp_ready = 1'b1;
    wait_drain(20);
    repeat (3) step();
    check("req034_one_rsp", resp_count - rc, 1);
    check("req034_flags", last_flags, 6'b000101);

    // Reset during EVAL discards the compare; next grant searches from 0.
    set_req(2, 32'h40400000, 32'h40400000);
    n = 0;
    while (sb.size() == 0 && n < 20) begin
      step();
      n++;
    end
    check("req035_in_eval", busy, 1);
    rst = 1'b1;
    #1;
    check("req035_rst_valid", rsp_valid, 0);
    check("req035_rst_busy", busy, 0);
    check("req035_rst_id", rsp_id, 0);
    check("req035_rst_flags", rsp_flags, 0);
`ifdef FCMP_ARB_UNORD_ERR_EN
    check("req035_rst_unord", unord_err, 0);
`endif
    step();
    step();
    rst = 1'b0;
    rc = resp_count;
    repeat (4) step();
    check("req035_no_rsp", resp_count - rc, 0);
    grants.delete();
    set_req(1, 32'h3F800000, 32'hBF800000);
    set_req(3, 32'h3F800000, 32'h3F800000);
    wait_drain(40);
    if (grants.size() >= 2) begin
      check("req035_grant_a", grants[0], 1);
      check("req035_grant_b", grants[1], 3);
    end else begin
      checks++;
      errors++;
      $display("FAIL req035_grants: got %0d grants expected 2", grants.size());
    end

    // Only 3 (at ptr-1), then only 0.
    grants.delete();
    set_req(3, 32'h7F800000, 32'h3F800000);
    wait_drain(20);
    check("req036_inf", last_flags[1], 1);
    set_req(0, 32'h7F800000, 32'h7F800000);
    wait_drain(20);
    if (grants.size() >= 2) begin
      check("req036_grant_a", grants[0], 3);
      check("req036_grant_b", grants[1], 0);
    end else begin
      checks++;
      errors++;
      $display("FAIL req036_grants: got %0d grants expected 2", grants.size());
    end

    // Randomized traffic with drops and backpressure.
    for (int c = 0; c < 800; c++) begin
      step();
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!vld[i] && $urandom_range(0, 2) == 0) begin
          vld[i]   = 1'b1;
          a_arr[i] = rand_op();
          b_arr[i] = ($urandom_range(0, 4) == 0) ? a_arr[i] : rand_op();
        end else if (vld[i] && $urandom_range(0, 9) == 0) begin
          vld[i] = 1'b0;
        end
      end
      drive();
    end
    vld = '0;
    rsp_ready = 1'b1;
    drive();
    wait_drain(40);
`ifdef FCMP_ARB_UNORD_ERR_EN
    check("random_unord_err", unord_err, model_unord);
`endif
    if (resp_count < 50) begin
      checks++;
      errors++;
      $display("FAIL response_volume: got %0d expected at least 50", resp_count);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
